pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Match sequencer for the Pong ball engine.
- Decides when the ball is held at centre, when it runs, and when play is frozen.
- Sequences serve countdown, rally, point pause and game over; owns both scores and the rally speed level.
- Sits between debounced user buttons, the ball engine's point/hit pulses and the score display; all timing is counted in frame ticks derived from vertical sync.

Parameters:
- WIN_SCORE, 10: score at which a player wins; legal range 1..15.
- SERVE_FRAMES, 60: frames the ball is held at centre before a serve.
- POINT_FRAMES, 90: frames play is frozen after a point.
- HITS_PER_LEVEL, 4: paddle hits per speed-level increment.
- MAX_LEVEL, 3: saturation value of speed_level.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  debounced one-cycle pulse
- pause_btn  in  1  debounced one-cycle pulse
- point_p1  in  1  one-cycle pulse: P1 scored (ball passed P2 paddle)
- point_p2  in  1  one-cycle pulse: P2 scored
- paddle_hit  in  1  one-cycle pulse: ball returned by either paddle
- ball_hold  out  1  1 = engine holds ball at centre
- ball_run  out  1  1 = engine advances ball
- serve_dir  out  1  0 = serve toward P1 (left), 1 = toward P2
- speed_level  out  2  rally speed index, 0..MAX_LEVEL
- p1_score  out  4  P1 points
- p2_score  out  4  P2 points
- game_over  out  1  match finished
- winner  out  1  0 = P1, 1 = P2; valid only while game_over = 1

Behaviour:
- Reset (reset = 0, asynchronous) values:
  - state IDLE
  - scores 0, speed_level 0, serve_dir 0
  - ball_hold 1, ball_run 0, game_over 0, winner 0
  - frame counter and hit counter 0
- All outputs are registered. An output changes in the cycle after the event that causes it.
- States: IDLE, SERVE, RALLY, PAUSED, POINT, DONE.
- IDLE:
  - ball_hold = 1.
  - On start_btn: clear scores, speed_level and hit counter; set serve_dir = 0; load the frame counter with SERVE_FRAMES-1; go to SERVE.
- SERVE:
  - ball_hold = 1.
  - The frame counter decrements on each frame_tick.
  - On frame_tick with counter = 0: go to RALLY.
  - Exactly SERVE_FRAMES ticks are counted from entry.
  - point, hit and pause inputs are ignored.
- RALLY:
  - ball_run = 1, ball_hold = 0.
  - paddle_hit increments the hit counter. When it reaches HITS_PER_LEVEL it clears to 0 and speed_level increments, saturating at MAX_LEVEL.
  - point_p1 or point_p2: increment that player's score and go to POINT. If both arrive in the same cycle, point_p1 takes priority and point_p2 is dropped. The ball has only one exit per rally, so this case is illegal at system level.
  - pause_btn: go to PAUSED. If a point pulse arrives in the same cycle, the point wins and the pause is dropped.
  - If a paddle_hit and a point pulse arrive in the same cycle, the hit is ignored.
- PAUSED:
  - ball_run = 0, ball_hold = 0 (ball frozen in place).
  - The frame counter is not touched.
  - pause_btn returns to RALLY.
  - Point and hit pulses are ignored.
- POINT:
  - ball_run = 0, ball_hold = 1.
  - On entry: serve_dir = direction toward the conceding player (point_p1 sets serve_dir = 1, point_p2 sets 0). Reset speed_level and the hit counter to 0. Load the frame counter with POINT_FRAMES-1.
  - If the updated score equals WIN_SCORE, go directly to DONE the next cycle and skip the countdown.
  - Otherwise, on frame_tick with counter = 0, load SERVE_FRAMES-1 and go to SERVE.
- DONE:
  - game_over = 1, ball_hold = 1, winner = scoring player.
  - Scores hold their values.
  - start_btn goes to IDLE. Scores are cleared on the next start, not on leaving DONE.
- Score width rule:
  - Scores saturate at 15.
  - The score compare uses the post-increment value, so a score can never exceed WIN_SCORE.
- frame_tick arriving in the same cycle as a state entry is not counted toward the new state.
- Parameter rule: the frame counter is wide enough for max(SERVE_FRAMES, POINT_FRAMES).
- start_btn is ignored outside IDLE and DONE. There is no mid-match restart except reset.
- Reset mid-operation returns to IDLE with all outputs at their reset values, regardless of state.

Decomposition:
- Shared package pong_pkg:
  - state encoding (one-hot, 6 bits)
  - SIDE_P1 = 0, SIDE_P2 = 1
  - default WIN_SCORE and frame constants, shared with the ball engine and the score display.
- One sub-module, pong_frame_timer: loadable down-counter.
  - Inputs: load and load value.
  - Decrements on frame_tick.
  - Output: expire, asserted when frame_tick arrives with count = 0.
  - Used for both the SERVE and POINT countdowns.

Test Plan:
- Reset, then start_btn -> ball_hold = 1 for exactly 60 frame_ticks. ball_run rises the cycle after the 60th tick; serve_dir = 0; scores 0/0.
- In RALLY, 9 paddle_hit pulses -> speed_level 0→1 after the 4th hit, 2 after the 8th, 2 after the 9th. Then point_p2 -> p2_score = 1, speed_level = 0, serve_dir = 0, ball_hold = 1 for 90 frames, then 60-frame SERVE.
- In RALLY, pause_btn -> ball_run = 0, ball_hold = 0. point_p1 and paddle_hit while PAUSED -> no change. pause_btn -> ball_run = 1.
- point_p1 and pause_btn in the same cycle -> p1_score +1, state POINT, not PAUSED. point_p1 and point_p2 together -> only p1_score increments.
- Drive p1 to 9, then point_p1 -> p1_score = 10, game_over = 1 next cycle, winner = 0, no countdown. start_btn -> IDLE. Next start_btn -> scores 0/0.
- Assert reset low mid-POINT countdown -> all outputs take reset values immediately (asynchronously). Release -> IDLE, awaits start_btn.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants: match-state encoding, side ids and default timing,
// used by the match sequencer, ball engine and score display.
package pong_pkg;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SERVE  = 6'b000010,
    ST_RALLY  = 6'b000100,
    ST_PAUSED = 6'b001000,
    ST_POINT  = 6'b010000,
    ST_DONE   = 6'b100000
  } state_e;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

  localparam int WIN_SCORE_DEF      = 10;
  localparam int SERVE_FRAMES_DEF   = 60;
  localparam int POINT_FRAMES_DEF   = 90;
  localparam int HITS_PER_LEVEL_DEF = 4;
  localparam int MAX_LEVEL_DEF      = 3;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Event inputs and play-control outputs of the Pong match sequencer.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       pause_btn;
  logic       point_p1;
  logic       point_p2;
  logic       paddle_hit;
  logic       ball_hold;
  logic       ball_run;
  logic       serve_dir;
  logic [1:0] speed_level;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       game_over;
  logic       winner;

  modport master (
    output frame_tick, start_btn, pause_btn, point_p1, point_p2, paddle_hit,
    input  ball_hold, ball_run, serve_dir, speed_level, p1_score, p2_score,
           game_over, winner
  );

  modport slave (
    input  frame_tick, start_btn, pause_btn, point_p1, point_p2, paddle_hit,
    output ball_hold, ball_run, serve_dir, speed_level, p1_score, p2_score,
           game_over, winner
  );
endinterface

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter; expire flags the tick that arrives at zero.
module pong_frame_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over a same-cycle tick, so the entry tick is never counted
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (tick && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign expire = tick && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, rally, pause, point freeze and game
// over; owns both scores, serve direction and the rally speed level.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES   = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES   = POINT_FRAMES_DEF,
  parameter int HITS_PER_LEVEL = HITS_PER_LEVEL_DEF,
  parameter int MAX_LEVEL      = MAX_LEVEL_DEF
) (
  input logic              clk,
  input logic              reset,
  pong_match_ctrl_if.slave bus
);

  localparam int FRAMES_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(FRAMES_MAX + 1);
  localparam int HIT_W      = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [HIT_W-1:0] HIT_WRAP = HIT_W'(HITS_PER_LEVEL);
  localparam logic [1:0]       LVL_MAX  = 2'(MAX_LEVEL);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [3:0]       p1_q, p1_d, p2_q, p2_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [HIT_W-1:0] hit_q, hit_d, hit_inc;
  logic             dir_q, dir_d, win_q, win_d;
  logic             hold_q, hold_d, run_q, run_d, over_q, over_d;
  logic             tmr_load, tmr_tick, tmr_exp;
  logic [CNT_W-1:0] tmr_val;

  // only the two countdown states let frames reach the timer
  assign tmr_tick = bus.frame_tick && (state_q == ST_SERVE || state_q == ST_POINT);

  pong_frame_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    lvl_d    = lvl_q;
    hit_d    = hit_q;
    dir_d    = dir_q;
    win_d    = win_q;
    tmr_load = 1'b0;
    tmr_val  = SERVE_LD;
    hit_inc  = hit_q + 1'b1;

    case (state_q)
      ST_IDLE: if (bus.start_btn) begin
        p1_d     = '0;
        p2_d     = '0;
        lvl_d    = '0;
        hit_d    = '0;
        dir_d    = SIDE_P1;
        tmr_load = 1'b1;
        state_d  = ST_SERVE;
      end

      ST_SERVE: if (tmr_exp) state_d = ST_RALLY;

      ST_RALLY: begin
        if (bus.point_p1 || bus.point_p2) begin
          // a point beats a same-cycle pause or hit; P1 wins a double point
          if (bus.point_p1) begin
            p1_d  = sat_inc4(p1_q);
            dir_d = SIDE_P2;
          end else begin
            p2_d  = sat_inc4(p2_q);
            dir_d = SIDE_P1;
          end
          lvl_d    = '0;
          hit_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = POINT_LD;
          state_d  = ST_POINT;
        end else begin
          if (bus.paddle_hit) begin
            if (hit_inc == HIT_WRAP) begin
              hit_d = '0;
              if (lvl_q != LVL_MAX) lvl_d = lvl_q + 1'b1;
            end else begin
              hit_d = hit_inc;
            end
          end
          if (bus.pause_btn) state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: if (bus.pause_btn) state_d = ST_RALLY;

      ST_POINT: begin
        if (p1_q == WIN || p2_q == WIN) begin
          win_d   = (p2_q == WIN) ? SIDE_P2 : SIDE_P1;
          state_d = ST_DONE;
        end else if (tmr_exp) begin
          tmr_load = 1'b1;
          state_d  = ST_SERVE;
        end
      end

      ST_DONE: if (bus.start_btn) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // ball/game flags are flopped from the next state so they stay glitch-free
  always_comb begin
    hold_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
             (state_d == ST_POINT) || (state_d == ST_DONE);
    run_d  = (state_d == ST_RALLY);
    over_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      lvl_q   <= '0;
      hit_q   <= '0;
      dir_q   <= SIDE_P1;
      win_q   <= SIDE_P1;
      hold_q  <= 1'b1;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      lvl_q   <= lvl_d;
      hit_q   <= hit_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  assign bus.ball_hold   = hold_q;
  assign bus.ball_run    = run_q;
  assign bus.serve_dir   = dir_q;
  assign bus.speed_level = lvl_q;
  assign bus.p1_score    = p1_q;
  assign bus.p2_score    = p2_q;
  assign bus.game_over   = over_q;
  assign bus.winner      = win_q;

endmodule
